// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART: parity-mode encodings,
// oversampling factor, bit-time counter width, FSM state encodings and
// helpers for deriving a bit time and a parity-enable flag from the
// run-time configuration inputs.
package uart_pkg;

    localparam int OVERSAMPLE = 8;
    localparam int BIT_CNT_W  = 19;

    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_EVEN = 2'b01;
    localparam logic [1:0] PARITY_ODD  = 2'b10;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

    // Bit time in clk cycles: max(prescale,1) * OVERSAMPLE.
    function automatic logic [BIT_CNT_W-1:0] bit_time(input logic [15:0] prescale);
        logic [BIT_CNT_W-1:0] p;
        p = (prescale == 16'd0) ? 19'd1 : {3'b000, prescale};
        return p << $clog2(OVERSAMPLE);
    endfunction

    // Mode 2'b11 is treated as "no parity".
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word fall-through synchronous FIFO used as the UART receive buffer.
// Ports:
//   clk, rst          clock and synchronous active-high reset (empties FIFO)
//   push, push_data   write request and data (ignored when full unless a pop
//                     happens in the same cycle)
//   pop               read request (ignored when empty)
//   head_data         current head entry, valid whenever level != 0
//   level             number of entries held (0..2**ADDR_W)
module uart_sync_fifo #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WIDTH-1:0]  push_data,
    input  logic              pop,
    output logic [WIDTH-1:0]  head_data,
    output logic [ADDR_W:0]   level
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [WIDTH-1:0]  mem [0:(2**ADDR_W)-1];
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W:0]   level_reg;
    logic              do_push;
    logic              do_pop;

    // The level counter alone decides full/empty; a pop frees the slot the
    // same-cycle push needs, so both succeed when full.
    assign do_pop  = pop && (level_reg != '0);
    assign do_push = push && ((level_reg != DEPTH) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Head is read combinationally so it is presented together with
    // tvalid in the cycle right after the push (fall-through behaviour).
    assign head_data = mem[rd_ptr_reg];
    assign level     = level_reg;

endmodule

// File: rtl/uart_cfg_fifo.sv
// AXI4-Stream UART with run-time parity / stop-bit configuration and a
// receive FIFO.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   input_axis_tdata/tvalid/tready   TX character stream (tready only in idle)
//   output_axis_tdata/tvalid/tready  RX FIFO head stream (pop on handshake)
//   rxd / txd                     serial in (asynchronous) / serial out
//   tx_busy / rx_busy             engine mid-frame
//   rx_overrun_error              pulse: good char dropped, FIFO full
//   rx_frame_error                pulse: first stop bit sampled low
//   rx_parity_error               pulse: parity mismatch
//   rx_fifo_level                 entries held in the RX FIFO
//   prescale, parity_mode, stop_bits  frame configuration, latched at frame start
module uart_cfg_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int RX_FIFO_ADDR_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   input_axis_tdata,
    input  logic                    input_axis_tvalid,
    output logic                    input_axis_tready,
    output logic [DATA_WIDTH-1:0]   output_axis_tdata,
    output logic                    output_axis_tvalid,
    input  logic                    output_axis_tready,
    input  logic                    rxd,
    output logic                    txd,
    output logic                    tx_busy,
    output logic                    rx_busy,
    output logic                    rx_overrun_error,
    output logic                    rx_frame_error,
    output logic                    rx_parity_error,
    output logic [RX_FIFO_ADDR_W:0] rx_fifo_level,
    input  logic [15:0]             prescale,
    input  logic [1:0]              parity_mode,
    input  logic                    stop_bits
);
    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);
    localparam logic [RX_FIFO_ADDR_W:0] FIFO_FULL = {1'b1, {RX_FIFO_ADDR_W{1'b0}}};

    logic [BIT_CNT_W-1:0] cfg_bt;
    assign cfg_bt = bit_time(prescale);

    // ---------------- TX engine ----------------
    tx_state_t             tx_state_reg, tx_state_next;
    logic [BIT_CNT_W-1:0]  tx_cnt_reg, tx_cnt_next;
    logic [BIT_CNT_W-1:0]  tx_bt_reg, tx_bt_next;
    logic [3:0]            tx_idx_reg, tx_idx_next;
    logic [DATA_WIDTH-1:0] tx_shift_reg, tx_shift_next;
    logic                  tx_par_en_reg, tx_par_en_next;
    logic                  tx_par_bit_reg, tx_par_bit_next;
    logic                  tx_stop2_reg, tx_stop2_next;
    logic                  txd_reg, txd_next;
    logic                  tready_reg;

    always_comb begin
        tx_state_next   = tx_state_reg;
        tx_cnt_next     = tx_cnt_reg;
        tx_bt_next      = tx_bt_reg;
        tx_idx_next     = tx_idx_reg;
        tx_shift_next   = tx_shift_reg;
        tx_par_en_next  = tx_par_en_reg;
        tx_par_bit_next = tx_par_bit_reg;
        tx_stop2_next   = tx_stop2_reg;
        txd_next        = txd_reg;
        // Every non-idle state counts down from T-1 and acts when it hits 0.
        if (tx_cnt_reg != '0) tx_cnt_next = tx_cnt_reg - 1'b1;
        case (tx_state_reg)
            TX_IDLE: begin
                txd_next = 1'b1;
                if (input_axis_tvalid && tready_reg) begin
                    tx_bt_next      = cfg_bt;
                    tx_cnt_next     = cfg_bt - 1'b1;
                    tx_shift_next   = input_axis_tdata;
                    tx_par_en_next  = parity_enabled(parity_mode);
                    tx_par_bit_next = (^input_axis_tdata) ^ (parity_mode == PARITY_ODD);
                    tx_stop2_next   = stop_bits;
                    tx_idx_next     = '0;
                    txd_next        = 1'b0;
                    tx_state_next   = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_reg == '0) begin
                    tx_cnt_next   = tx_bt_reg - 1'b1;
                    txd_next      = tx_shift_reg[0];
                    tx_state_next = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt_reg == '0) begin
                    tx_cnt_next = tx_bt_reg - 1'b1;
                    if (tx_idx_reg == LAST_BIT) begin
                        if (tx_par_en_reg) begin
                            txd_next      = tx_par_bit_reg;
                            tx_state_next = TX_PARITY;
                        end else begin
                            txd_next      = 1'b1;
                            tx_state_next = TX_STOP;
                        end
                    end else begin
                        tx_idx_next   = tx_idx_reg + 1'b1;
                        tx_shift_next = {1'b0, tx_shift_reg[DATA_WIDTH-1:1]};
                        txd_next      = tx_shift_reg[1];
                    end
                end
            end
            TX_PARITY: begin
                if (tx_cnt_reg == '0) begin
                    tx_cnt_next   = tx_bt_reg - 1'b1;
                    txd_next      = 1'b1;
                    tx_state_next = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_cnt_reg == '0) begin
                    if (tx_stop2_reg) begin
                        tx_stop2_next = 1'b0;
                        tx_cnt_next   = tx_bt_reg - 1'b1;
                    end else begin
                        tx_state_next = TX_IDLE;
                    end
                end
            end
            default: begin
                txd_next      = 1'b1;
                tx_state_next = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_reg   <= TX_IDLE;
            tx_cnt_reg     <= '0;
            tx_bt_reg      <= '0;
            tx_idx_reg     <= '0;
            tx_shift_reg   <= '0;
            tx_par_en_reg  <= 1'b0;
            tx_par_bit_reg <= 1'b0;
            tx_stop2_reg   <= 1'b0;
            txd_reg        <= 1'b1;
            tready_reg     <= 1'b0;
        end else begin
            tx_state_reg   <= tx_state_next;
            tx_cnt_reg     <= tx_cnt_next;
            tx_bt_reg      <= tx_bt_next;
            tx_idx_reg     <= tx_idx_next;
            tx_shift_reg   <= tx_shift_next;
            tx_par_en_reg  <= tx_par_en_next;
            tx_par_bit_reg <= tx_par_bit_next;
            tx_stop2_reg   <= tx_stop2_next;
            txd_reg        <= txd_next;
            // Registered so tready stays low through the reset cycle and
            // rises the cycle after a frame's last stop bit.
            tready_reg     <= (tx_state_next == TX_IDLE);
        end
    end

    assign txd               = txd_reg;
    assign input_axis_tready = tready_reg;
    assign tx_busy           = (tx_state_reg != TX_IDLE);

    // ---------------- RX engine ----------------
    rx_state_t             rx_state_reg, rx_state_next;
    logic [BIT_CNT_W-1:0]  rx_cnt_reg, rx_cnt_next;
    logic [BIT_CNT_W-1:0]  rx_bt_reg, rx_bt_next;
    logic [3:0]            rx_idx_reg, rx_idx_next;
    logic [DATA_WIDTH-1:0] rx_shift_reg, rx_shift_next;
    logic                  rx_par_en_reg, rx_par_en_next;
    logic                  rx_par_odd_reg, rx_par_odd_next;
    logic                  rx_par_bit_reg, rx_par_bit_next;
    logic                  rxd_meta_reg, rxd_sync_reg, rxd_prev_reg;
    logic                  frame_err_reg, frame_err_next;
    logic                  parity_err_reg, parity_err_next;
    logic                  overrun_reg, overrun_next;
    logic                  rx_push;
    logic                  rx_pop;
    logic                  bad_frame;
    logic                  bad_parity;

    assign rx_pop = output_axis_tvalid && output_axis_tready;

    always_comb begin
        rx_state_next   = rx_state_reg;
        rx_cnt_next     = rx_cnt_reg;
        rx_bt_next      = rx_bt_reg;
        rx_idx_next     = rx_idx_reg;
        rx_shift_next   = rx_shift_reg;
        rx_par_en_next  = rx_par_en_reg;
        rx_par_odd_next = rx_par_odd_reg;
        rx_par_bit_next = rx_par_bit_reg;
        frame_err_next  = 1'b0;
        parity_err_next = 1'b0;
        overrun_next    = 1'b0;
        rx_push         = 1'b0;
        bad_frame       = !rxd_sync_reg;
        bad_parity      = rx_par_en_reg &&
                          (rx_par_bit_reg != ((^rx_shift_reg) ^ rx_par_odd_reg));
        if (rx_cnt_reg != '0) rx_cnt_next = rx_cnt_reg - 1'b1;
        case (rx_state_reg)
            RX_IDLE: begin
                if (rxd_prev_reg && !rxd_sync_reg) begin
                    rx_bt_next      = cfg_bt;
                    rx_cnt_next     = (cfg_bt >> 1) - 1'b1;
                    rx_par_en_next  = parity_enabled(parity_mode);
                    rx_par_odd_next = (parity_mode == PARITY_ODD);
                    rx_state_next   = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_reg == '0) begin
                    if (rxd_sync_reg) begin
                        rx_state_next = RX_IDLE;     // glitch, silently ignored
                    end else begin
                        rx_cnt_next   = rx_bt_reg - 1'b1;
                        rx_idx_next   = '0;
                        rx_state_next = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (rx_cnt_reg == '0) begin
                    rx_cnt_next   = rx_bt_reg - 1'b1;
                    // LSB arrives first, so shift in from the top.
                    rx_shift_next = {rxd_sync_reg, rx_shift_reg[DATA_WIDTH-1:1]};
                    if (rx_idx_reg == LAST_BIT) begin
                        rx_state_next = rx_par_en_reg ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_idx_next = rx_idx_reg + 1'b1;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_cnt_reg == '0) begin
                    rx_cnt_next     = rx_bt_reg - 1'b1;
                    rx_par_bit_next = rxd_sync_reg;
                    rx_state_next   = RX_STOP;
                end
            end
            RX_STOP: begin
                // Only the first stop bit is checked; a second one is implied
                // by the falling-edge requirement for the next start bit.
                if (rx_cnt_reg == '0) begin
                    frame_err_next  = bad_frame;
                    parity_err_next = bad_parity;
                    if (!bad_frame && !bad_parity) begin
                        if ((rx_fifo_level == FIFO_FULL) && !rx_pop) begin
                            overrun_next = 1'b1;
                        end else begin
                            rx_push = 1'b1;
                        end
                    end
                    rx_state_next = bad_frame ? RX_WAIT_IDLE : RX_IDLE;
                end
            end
            RX_WAIT_IDLE: begin
                if (rxd_sync_reg) rx_state_next = RX_IDLE;
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_reg   <= RX_IDLE;
            rx_cnt_reg     <= '0;
            rx_bt_reg      <= '0;
            rx_idx_reg     <= '0;
            rx_shift_reg   <= '0;
            rx_par_en_reg  <= 1'b0;
            rx_par_odd_reg <= 1'b0;
            rx_par_bit_reg <= 1'b0;
            rxd_meta_reg   <= 1'b1;
            rxd_sync_reg   <= 1'b1;
            rxd_prev_reg   <= 1'b1;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            rx_state_reg   <= rx_state_next;
            rx_cnt_reg     <= rx_cnt_next;
            rx_bt_reg      <= rx_bt_next;
            rx_idx_reg     <= rx_idx_next;
            rx_shift_reg   <= rx_shift_next;
            rx_par_en_reg  <= rx_par_en_next;
            rx_par_odd_reg <= rx_par_odd_next;
            rx_par_bit_reg <= rx_par_bit_next;
            rxd_meta_reg   <= rxd;
            rxd_sync_reg   <= rxd_meta_reg;
            rxd_prev_reg   <= rxd_sync_reg;
            frame_err_reg  <= frame_err_next;
            parity_err_reg <= parity_err_next;
            overrun_reg    <= overrun_next;
        end
    end

    assign rx_busy          = (rx_state_reg != RX_IDLE);
    assign rx_frame_error   = frame_err_reg;
    assign rx_parity_error  = parity_err_reg;
    assign rx_overrun_error = overrun_reg;
    assign output_axis_tvalid = (rx_fifo_level != '0);

    uart_sync_fifo #(
        .WIDTH  (DATA_WIDTH),
        .ADDR_W (RX_FIFO_ADDR_W)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (rx_shift_reg),
        .pop       (rx_pop),
        .head_data (output_axis_tdata),
        .level     (rx_fifo_level)
    );

endmodule

// File: tb/tb_uart_cfg_fifo.sv
// Directed bench for uart_cfg_fifo (DATA_WIDTH=8, 4-entry RX FIFO).
module tb_uart_cfg_fifo;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  input_axis_tdata;
    logic        input_axis_tvalid;
    logic        input_axis_tready;
    logic [7:0]  output_axis_tdata;
    logic        output_axis_tvalid;
    logic        output_axis_tready;
    logic        rxd;
    logic        txd;
    logic        tx_busy, rx_busy;
    logic        rx_overrun_error, rx_frame_error, rx_parity_error;
    logic [2:0]  rx_fifo_level;
    logic [15:0] prescale;
    logic [1:0]  parity_mode;
    logic        stop_bits;
    logic        loop_en;
    logic        rxd_drv;

    int total = 0;
    int bad   = 0;
    int par_cnt = 0, frm_cnt = 0, ovr_cnt = 0;
    int par0, frm0, ovr0;
    int rcv_cnt;
    int low_cnt;

    assign rxd = loop_en ? txd : rxd_drv;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_parity_error)  par_cnt++;
        if (rx_frame_error)   frm_cnt++;
        if (rx_overrun_error) ovr_cnt++;
    end

    uart_cfg_fifo #(.DATA_WIDTH(8), .RX_FIFO_ADDR_W(2)) dut (
        .clk(clk), .rst(rst),
        .input_axis_tdata(input_axis_tdata), .input_axis_tvalid(input_axis_tvalid),
        .input_axis_tready(input_axis_tready),
        .output_axis_tdata(output_axis_tdata), .output_axis_tvalid(output_axis_tvalid),
        .output_axis_tready(output_axis_tready),
        .rxd(rxd), .txd(txd), .tx_busy(tx_busy), .rx_busy(rx_busy),
        .rx_overrun_error(rx_overrun_error), .rx_frame_error(rx_frame_error),
        .rx_parity_error(rx_parity_error), .rx_fifo_level(rx_fifo_level),
        .prescale(prescale), .parity_mode(parity_mode), .stop_bits(stop_bits)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic send_char(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        while (!input_axis_tready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!input_axis_tready) check("send_ready", {31'd0, input_axis_tready}, 1);
        input_axis_tdata  = d;
        input_axis_tvalid = 1'b1;
        @(posedge clk);
        #1 input_axis_tvalid = 1'b0;
    endtask

    // Drive one frame on rxd at T = 8 cycles, no second stop bit.
    task automatic drive_frame(input logic [7:0] d, input logic with_par, input logic par_val);
        rxd_drv = 1'b0;
        repeat (8) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            rxd_drv = d[b];
            repeat (8) @(negedge clk);
        end
        if (with_par) begin
            rxd_drv = par_val;
            repeat (8) @(negedge clk);
        end
        rxd_drv = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        logic [9:0] exp_a5;
        logic [7:0] v;
        rst = 1'b1;
        input_axis_tdata = '0;
        input_axis_tvalid = 1'b0;
        output_axis_tready = 1'b0;
        rxd_drv = 1'b1;
        loop_en = 1'b0;
        prescale = 16'd1;
        parity_mode = 2'b00;
        stop_bits = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_txd",    {31'd0, txd}, 1);
        check("rst_tready", {31'd0, input_axis_tready}, 0);
        check("rst_tvalid", {31'd0, output_axis_tvalid}, 0);
        check("rst_busy",   {30'd0, tx_busy, rx_busy}, 0);
        check("rst_level",  {29'd0, rx_fifo_level}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("tready_after_rst", {31'd0, input_axis_tready}, 1);

        // 8N1 transmit of 0xA5: start, 1,0,1,0,0,1,0,1, stop
        exp_a5 = 10'b1_10100101_0;
        input_axis_tdata = 8'hA5;
        input_axis_tvalid = 1'b1;
        @(posedge clk);
        #1 input_axis_tvalid = 1'b0;
        low_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (i % 8 == 4) check($sformatf("a5_bit%0d", i / 8), {31'd0, txd}, {31'd0, exp_a5[i / 8]});
            if (i == 40) check("a5_busy_mid", {31'd0, tx_busy}, 1);
            if (!input_axis_tready) low_cnt++;
        end
        check("a5_tready_low_cycles", low_cnt, 80);
        @(negedge clk);
        check("a5_tready_back", {31'd0, input_axis_tready}, 1);
        check("a5_busy_end", {31'd0, tx_busy}, 0);

        // Loopback, even parity, two stop bits, 0x00..0x0F back-to-back
        loop_en = 1'b1;
        parity_mode = 2'b01;
        stop_bits = 1'b1;
        output_axis_tready = 1'b1;
        par0 = par_cnt; frm0 = frm_cnt; ovr0 = ovr_cnt;
        rcv_cnt = 0;
        fork
            begin
                for (int c = 0; c < 16; c++) send_char(8'(c));
            end
            begin
                int n = 0;
                while (rcv_cnt < 16 && n < 4000) begin
                    @(negedge clk);
                    n++;
                    if (output_axis_tvalid) begin
                        check($sformatf("loop_char%0d", rcv_cnt), {24'd0, output_axis_tdata}, rcv_cnt);
                        rcv_cnt++;
                    end
                end
            end
        join
        check("loop_count", rcv_cnt, 16);
        check("loop_errors", (par_cnt - par0) + (frm_cnt - frm0) + (ovr_cnt - ovr0), 0);

        // Odd parity: 0x3C has four ones, so the correct parity bit is 1
        repeat (20) @(negedge clk);
        loop_en = 1'b0;
        rxd_drv = 1'b1;
        output_axis_tready = 1'b0;
        parity_mode = 2'b10;
        stop_bits = 1'b0;
        repeat (5) @(negedge clk);
        par0 = par_cnt; frm0 = frm_cnt;
        drive_frame(8'h3C, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        check("par_bad_pulses", par_cnt - par0, 1);
        check("par_bad_no_frm", frm_cnt - frm0, 0);
        check("par_bad_level", {29'd0, rx_fifo_level}, 0);
        drive_frame(8'h3C, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        check("par_good_level", {29'd0, rx_fifo_level}, 1);
        check("par_good_data", {24'd0, output_axis_tdata}, 32'h3C);
        check("par_good_no_err", par_cnt - par0, 1);
        output_axis_tready = 1'b1;
        @(negedge clk);
        output_axis_tready = 1'b0;
        check("par_pop_level", {29'd0, rx_fifo_level}, 0);

        // Overrun: 5 chars into a 4-entry FIFO with the consumer stalled
        loop_en = 1'b1;
        parity_mode = 2'b00;
        ovr0 = ovr_cnt;
        for (int k = 0; k < 5; k++) begin
            v = 8'(8'h11 * (k + 1));
            send_char(v);
        end
        repeat (150) @(negedge clk);
        check("ovr_level", {29'd0, rx_fifo_level}, 4);
        check("ovr_pulses", ovr_cnt - ovr0, 1);
        check("ovr_head", {24'd0, output_axis_tdata}, 32'h11);
        output_axis_tready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ovr_pop%0d", k), {24'd0, output_axis_tdata}, 32'h11 * (k + 1));
            @(negedge clk);
        end
        output_axis_tready = 1'b0;
        check("ovr_drained", {28'd0, output_axis_tvalid, rx_fifo_level}, 0);

        // Break: rxd held low past the stop sample, then released
        loop_en = 1'b0;
        rxd_drv = 1'b1;
        repeat (5) @(negedge clk);
        frm0 = frm_cnt; par0 = par_cnt;
        rxd_drv = 1'b0;
        repeat (90) @(negedge clk);
        check("brk_frame_pulse", frm_cnt - frm0, 1);
        check("brk_busy_low", {31'd0, rx_busy}, 1);
        repeat (6) @(negedge clk);
        check("brk_busy_held", {31'd0, rx_busy}, 1);
        rxd_drv = 1'b1;
        repeat (5) @(negedge clk);
        check("brk_busy_released", {31'd0, rx_busy}, 0);
        check("brk_no_push", {29'd0, rx_fifo_level}, 0);
        check("brk_single_pulse", (frm_cnt - frm0) + (par_cnt - par0), 1);

        // Reset mid-TX and mid-RX with one char already buffered
        loop_en = 1'b1;
        send_char(8'h77);
        repeat (120) @(negedge clk);
        check("pre_rst_level", {29'd0, rx_fifo_level}, 1);
        send_char(8'h99);
        repeat (30) @(negedge clk);
        check("pre_rst_busy", {30'd0, tx_busy, rx_busy}, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_txd",    {31'd0, txd}, 1);
        check("mid_rst_tready", {31'd0, input_axis_tready}, 0);
        check("mid_rst_tvalid", {31'd0, output_axis_tvalid}, 0);
        check("mid_rst_level",  {29'd0, rx_fifo_level}, 0);
        check("mid_rst_busy",   {30'd0, tx_busy, rx_busy}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_tready", {31'd0, input_axis_tready}, 1);
        send_char(8'h5A);
        repeat (120) @(negedge clk);
        check("post_rst_level", {29'd0, rx_fifo_level}, 1);
        check("post_rst_data", {24'd0, output_axis_tdata}, 32'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
